// File: rtl/disp_pkg.sv
// Shared display constants: active-low glyphs, blanking values and the wildcard code.
// Any controller that emits the wildcard glyph compares against WILDCARD_CODE from here.
package disp_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic [6:0] GLYPH_WILD = 7'b0110110;
    localparam logic [6:0] GLYPH_DASH = 7'b0111111;

    localparam logic [3:0] WILDCARD_CODE = 4'd10;

    // Segment order {g,f,e,d,c,b,a}, 0 = lit
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational 4-bit digit value to active-low seven-segment glyph.
// Codes above the wildcard code all render as a dash.
module seg_glyph_decode
    import disp_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_DASH;
        case (value)
            4'd0:          glyph = GLYPH_0;
            4'd1:          glyph = GLYPH_1;
            4'd2:          glyph = GLYPH_2;
            4'd3:          glyph = GLYPH_3;
            4'd4:          glyph = GLYPH_4;
            4'd5:          glyph = GLYPH_5;
            4'd6:          glyph = GLYPH_6;
            4'd7:          glyph = GLYPH_7;
            4'd8:          glyph = GLYPH_8;
            4'd9:          glyph = GLYPH_9;
            WILDCARD_CODE: glyph = GLYPH_WILD;
            default:       glyph = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/disp_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-latched inputs,
// per-slot anode guard band and per-digit blink gating.
module disp_scan_driver
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD_CYC   = 16,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] blink_mask,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int unsigned SlotW  = $clog2(REFRESH_DIV);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV);

    localparam logic [SlotW-1:0]  SlotLast  = SlotW'(REFRESH_DIV - 1);
    localparam logic [SlotW-1:0]  SlotGuard = SlotW'(GUARD_CYC);
    localparam logic [SlotW-1:0]  SlotOne   = SlotW'(1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkOne  = BlinkW'(1);

    logic [SlotW-1:0]  slot_cnt_q;
    logic [1:0]        scan_idx_q;
    logic [BlinkW-1:0] blink_cnt_q;
    logic              blink_phase_q;
    logic              first_q;
    logic [3:0][3:0]   shadow_q;
    logic [3:0]        shadow_mask_q;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;
    logic              frame_tick_q;

    logic       slot_wrap;
    logic       blink_wrap;
    logic       frame_start;
    logic [6:0] cur_glyph;

    assign slot_wrap   = (slot_cnt_q == SlotLast);
    assign blink_wrap  = (blink_cnt_q == BlinkLast);
    // The first cycle after reset release latches a fresh frame as well
    assign frame_start = first_q || (slot_wrap && (scan_idx_q == 2'd3));

    seg_glyph_decode u_decode (
        .value (shadow_q[scan_idx_q]),
        .glyph (cur_glyph)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (slot_cnt_q >= SlotGuard) begin
            an_d = ~(4'b0001 << scan_idx_q);
            // Blinking digits keep their anode so the duty cycle stays uniform
            if (!(shadow_mask_q[scan_idx_q] && blink_phase_q)) begin
                seg_d = cur_glyph;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt_q    <= '0;
            scan_idx_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            first_q       <= 1'b1;
            shadow_q      <= '0;
            shadow_mask_q <= '0;
            seg_q         <= SEG_BLANK;
            an_q          <= AN_OFF;
            frame_tick_q  <= 1'b0;
        end else begin
            first_q    <= 1'b0;
            slot_cnt_q <= slot_wrap ? '0 : slot_cnt_q + SlotOne;
            if (slot_wrap) begin
                scan_idx_q <= scan_idx_q + 2'd1;
            end
            blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + BlinkOne;
            if (blink_wrap) begin
                blink_phase_q <= ~blink_phase_q;
            end
            if (frame_start) begin
                shadow_q      <= {digit3, digit2, digit1, digit0};
                shadow_mask_q <= blink_mask;
            end
            frame_tick_q <= frame_start;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Scoreboard bench for disp_scan_driver: expected lit windows are queued per frame,
// a monitor pops one per completed anode window and checks anode, glyph and width.
module tb_disp_scan_driver;

    localparam int unsigned RD = 8;
    localparam int unsigned GC = 2;
    localparam int unsigned BD = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] digit0, digit1, digit2, digit3, blink_mask;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;
    int frame_idx = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t exp_q[$];

    disp_scan_driver #(
        .REFRESH_DIV (RD),
        .GUARD_CYC   (GC),
        .BLINK_DIV   (BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .blink_mask (blink_mask),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph_of(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'd10:   return 7'b0110110;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected windows for the frame just latched; blink phase flips every two frames
    task automatic push_frame();
        exp_t       e;
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       begin d = digit0; e.an = 4'b1110; end
                1:       begin d = digit1; e.an = 4'b1101; end
                2:       begin d = digit2; e.an = 4'b1011; end
                default: begin d = digit3; e.an = 4'b0111; end
            endcase
            e.seg = (blink_mask[i] && frame_idx[1]) ? 7'b1111111 : glyph_of(d);
            exp_q.push_back(e);
        end
    endtask

    task automatic next_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        check("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
        push_frame();
        frame_idx++;
    endtask

    // Monitor: one scoreboard entry per contiguous lit-anode window
    logic       in_win = 1'b0;
    logic       stable;
    logic [3:0] w_an;
    logic [6:0] w_seg;
    int         w_len;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_win = 1'b0;
            end else begin
                check("an_at_most_one_low", {31'd0, ($countones(~an) <= 1)}, 32'd1);
                if (an != 4'b1111) begin
                    if (!in_win) begin
                        in_win = 1'b1;
                        w_an   = an;
                        w_seg  = seg;
                        w_len  = 1;
                        stable = 1'b1;
                    end else begin
                        w_len++;
                        if (an != w_an || seg != w_seg) stable = 1'b0;
                    end
                end else if (in_win) begin
                    in_win = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_window", {28'd0, w_an}, 32'hf);
                    end else begin
                        e = exp_q.pop_front();
                        check("win_an", {28'd0, w_an}, {28'd0, e.an});
                        check("win_seg", {25'd0, w_seg}, {25'd0, e.seg});
                        check("win_len", w_len, RD - GC);
                        check("win_stable", {31'd0, stable}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        {digit3, digit2, digit1, digit0} = {4'd4, 4'd3, 4'd2, 4'd1};
        blink_mask = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_an", {28'd0, an}, 32'hf);
        check("reset_seg", {25'd0, seg}, 32'h7f);
        check("reset_tick", {31'd0, frame_tick}, 32'd0);

        // Release: tick next cycle, two blank cycles, then digit 0 lit
        frame_idx = 0;
        rst = 1'b1;
        next_frame(n);
        check("release_tick_latency", n, 1);
        check("release_an_blank0", {28'd0, an}, 32'hf);
        @(negedge clk);
        check("release_an_blank1", {28'd0, an}, 32'hf);
        check("tick_one_cycle", {31'd0, frame_tick}, 32'd0);
        @(negedge clk);
        check("first_lit_an", {28'd0, an}, 32'he);
        check("first_lit_seg", {25'd0, seg}, 32'h79);
        next_frame(n);
        next_frame(n);
        check("frame_period", n, 32);

        // Wildcard and dash glyphs
        digit0 = 4'd10;
        digit1 = 4'd13;
        next_frame(n);
        next_frame(n);
        next_frame(n);
        check("frame_period_2", n, 32);

        // Mid-frame change must not tear the current frame
        digit2 = 4'd5;
        next_frame(n);
        repeat (12) @(negedge clk);
        check("mid_frame_slot1", {28'd0, an}, 32'hd);
        digit2 = 4'd7;
        next_frame(n);
        next_frame(n);

        // Blink on digit 0 across both phases
        {digit3, digit2, digit1, digit0} = {4'd8, 4'd8, 4'd8, 4'd8};
        blink_mask = 4'b0001;
        for (int i = 0; i < 6; i++) next_frame(n);

        // Reset in the middle of slot 2
        repeat (20) @(negedge clk);
        check("pre_reset_slot2", {28'd0, an}, 32'hb);
        rst = 1'b0;
        #1;
        check("midreset_an", {28'd0, an}, 32'hf);
        check("midreset_seg", {25'd0, seg}, 32'h7f);
        check("midreset_tick", {31'd0, frame_tick}, 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        {digit3, digit2, digit1, digit0} = {4'd9, 4'd6, 4'd0, 4'd15};
        blink_mask = 4'b0000;
        frame_idx = 0;
        rst = 1'b1;
        next_frame(n);
        check("rerelease_tick_latency", n, 1);
        @(negedge clk);
        check("rerelease_blank", {28'd0, an}, 32'hf);
        @(negedge clk);
        check("rerelease_an", {28'd0, an}, 32'he);
        check("rerelease_seg", {25'd0, seg}, 32'h3f);
        next_frame(n);
        next_frame(n);
        repeat (40) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
